// File: rtl/filter_result_capture.sv
// Capture stage behind the masked rank-order filter: drops pipeline-fill samples,
// stores a fixed-length run in on-chip RAM, and offers a button-stepped readout port.
module filter_result_capture #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int SKIP      = 0,
  parameter int COUNT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS:0]   wr_count,
  output logic                 busy,
  output logic                 done
);

  localparam int SKIP_BITS = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_BITS-1:0] SKIP_LAST  = SKIP_BITS'(SKIP);
  localparam logic [ADDR_BITS:0]   COUNT_LAST = (ADDR_BITS + 1)'(COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SKIP_BITS-1:0]   skip_cnt_q, skip_cnt_d;
  logic [ADDR_BITS:0]     wr_count_q, wr_count_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                   step_q;
  logic                   rd_valid_q;
  logic                   wr_en;
  logic [DATA_BITS-1:0]   mem_rd_q;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  // start wins over everything, including an in_valid in the same cycle.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    if (start) begin
      state_d    = (SKIP > 0) ? S_SKIP : S_CAPTURE;
      skip_cnt_d = '0;
      wr_count_d = '0;
    end else begin
      case (state_q)
        S_SKIP: begin
          if (in_valid) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
            if (skip_cnt_d == SKIP_LAST) state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            wr_en      = 1'b1;
            wr_count_d = wr_count_q + 1'b1;
            if (wr_count_d == COUNT_LAST) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer moves only on a step_up rising edge; step_down just picks the direction.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (step_up && !step_q) begin
      rd_addr_d = step_down ? rd_addr_q - 1'b1 : rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      wr_count_q <= '0;
      rd_addr_q  <= '0;
      step_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      wr_count_q <= wr_count_d;
      rd_addr_q  <= rd_addr_d;
      step_q     <= step_up;
      rd_valid_q <= ({1'b0, rd_addr_q} < wr_count_q);
    end
  end

  // Reset-free array and read register so the RAM maps to block memory (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count_q[ADDR_BITS-1:0]] <= in_data;
    mem_rd_q <= mem[rd_addr_q];
  end

  assign rd_data  = rd_valid_q ? mem_rd_q : '0;
  assign rd_addr  = rd_addr_q;
  assign wr_count = wr_count_q;
  assign busy     = (state_q == S_SKIP) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_filter_result_capture.sv
// Directed bench for filter_result_capture: two instances (SKIP=3/COUNT=4 and
// SKIP=0/COUNT=3), read expectations queued at stimulus time and popped at output.
module tb_filter_result_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, in_valid_a, in_valid_b;
  logic [7:0] in_data;
  logic       step_up_a, step_up_b, step_down;

  logic [7:0] rd_addr_a, rd_data_a, rd_addr_b, rd_data_b;
  logic [8:0] wr_count_a, wr_count_b;
  logic       busy_a, done_a, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_a [256];
  int         cnt_a;
  logic [7:0] rd_a;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  filter_result_capture #(.DATA_BITS(8), .DEPTH(256), .SKIP(3), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_data(in_data),
    .step_up(step_up_a), .step_down(step_down), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_count(wr_count_a), .busy(busy_a), .done(done_a)
  );

  filter_result_capture #(.DATA_BITS(8), .DEPTH(256), .SKIP(0), .COUNT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_data(in_data),
    .step_up(step_up_b), .step_down(step_down), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_count(wr_count_b), .busy(busy_b), .done(done_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step_up pulse on instance A; address checked right away, data one cycle later.
  task automatic step_a(input logic down);
    step_down = down;
    step_up_a = 1'b1;
    tick();
    rd_a = down ? rd_a - 8'd1 : rd_a + 8'd1;
    chk("rd_addr_a", rd_addr_a, rd_a);
    exp_q.push_back((int'(rd_a) < cnt_a) ? mem_a[rd_a] : 8'h00);
    step_up_a = 1'b0;
    step_down = 1'b0;
    tick();
    chk("rd_data_a", rd_data_a, exp_q.pop_front());
  endtask

  initial begin
    logic       pat_v [5];
    logic [7:0] pat_d [5];
    pat_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_d = '{8'hA1, 8'h55, 8'hA2, 8'h66, 8'hA3};

    rst = 1'b0; start_a = 0; start_b = 0; in_valid_a = 0; in_valid_b = 0;
    in_data = 8'h00; step_up_a = 0; step_up_b = 0; step_down = 0;
    cnt_a = 0; rd_a = 8'd0;
    tick(); tick();
    chk("reset_rd_addr", rd_addr_a, 0);
    chk("reset_rd_data", rd_data_a, 0);
    chk("reset_wr_count", wr_count_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    rst = 1'b1;
    tick();

    // SKIP=3, COUNT=4 run with 8 back-to-back samples
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("start_busy", busy_a, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data    = 8'h10 + 8'(i);
      tick();
      if (i == 5) chk("done_before_7th", done_a, 0);
      if (i == 6) chk("done_after_7th", done_a, 1);
    end
    in_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) mem_a[k] = 8'h13 + 8'(k);
    cnt_a = 4;
    chk("wr_count_a", wr_count_a, 4);
    chk("busy_after_done", busy_a, 0);
    exp_q.push_back(mem_a[0]);
    tick();
    chk("rd_data_addr0", rd_data_a, exp_q.pop_front());

    // readout and wrap
    step_a(1'b0);
    step_a(1'b0);
    step_a(1'b1);
    step_down = 1'b1; tick(); tick(); step_down = 1'b0;
    chk("step_down_alone", rd_addr_a, rd_a);
    step_a(1'b1);
    step_a(1'b1);
    step_a(1'b0);

    // gapped valids on B (SKIP=0, COUNT=3)
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_b = pat_v[i];
      in_data    = pat_d[i];
      tick();
      if (i == 3) chk("gap_done_early", done_b, 0);
      if (i == 4) chk("gap_done", done_b, 1);
    end
    in_valid_b = 1'b0;
    chk("gap_wr_count", wr_count_b, 3);
    exp_q.push_back(8'hA1);
    tick();
    chk("gap_rd0", rd_data_b, exp_q.pop_front());
    step_up_b = 1'b1; tick();
    chk("gap_rd_addr_b", rd_addr_b, 1);
    exp_q.push_back(8'hA2);
    step_up_b = 1'b0; tick();
    chk("gap_rd1", rd_data_b, exp_q.pop_front());

    // restart mid-capture on B
    start_b = 1'b1; tick(); start_b = 1'b0;
    in_valid_b = 1'b1; in_data = 8'hB0; tick();
    in_data = 8'hB1; tick();
    in_valid_b = 1'b0;
    chk("restart_pre_count", wr_count_b, 2);
    start_b = 1'b1; in_valid_b = 1'b1; in_data = 8'hEE; tick();
    start_b = 1'b0; in_valid_b = 1'b0;
    chk("restart_count", wr_count_b, 0);
    chk("restart_busy", busy_b, 1);
    tick();
    chk("restart_rd1_empty", rd_data_b, 0);
    in_valid_b = 1'b1; in_data = 8'hC0; tick(); in_valid_b = 1'b0;
    chk("restart_first_write", wr_count_b, 1);
    tick();
    chk("restart_rd1_still0", rd_data_b, 0);
    in_valid_b = 1'b1; in_data = 8'hC1; tick(); in_valid_b = 1'b0;
    exp_q.push_back(8'hC1);
    tick();
    chk("restart_rd1_new", rd_data_b, exp_q.pop_front());

    // async reset mid-capture on A, no clock edge in between
    step_a(1'b0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h50 + 8'(i);
      tick();
    end
    in_valid_a = 1'b0;
    chk("pre_reset_count", wr_count_a, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", busy_a, 0);
    chk("async_done", done_a, 0);
    chk("async_rd_addr", rd_addr_a, 0);
    chk("async_wr_count", wr_count_a, 0);
    chk("async_rd_data", rd_data_a, 0);
    tick();
    rst = 1'b1;
    rd_a = 8'd0;
    tick();

    start_a = 1'b1; tick(); start_a = 1'b0;
    in_valid_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'h40 + 8'(i) - 8'd3;
      tick();
    end
    in_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) mem_a[k] = 8'h40 + 8'(k);
    cnt_a = 4;
    chk("post_reset_done", done_a, 1);
    chk("post_reset_count", wr_count_a, 4);
    exp_q.push_back(mem_a[0]);
    tick();
    chk("post_reset_rd0", rd_data_a, exp_q.pop_front());
    step_a(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
